mux2_pkt_arb: RTL and testbench

MUX2_PKT_ARB -- requirements
Module: mux2_pkt_arb

---
 rtl/mux2_pkt_arb_pkg.sv | 12 +
 rtl/mux2_pkt_arb_pipe_reg.sv | 34 +++
 rtl/mux2_pkt_arb.sv | 98 +++++++++
 tb/tb_mux2_pkt_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_pkt_arb_pkg.sv
// Shared types and defaults for the two-stream packet arbiter.
package mux2_pkt_arb_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/mux2_pkt_arb_pipe_reg.sv
// One-entry output register with valid/ready hold.
module pipe_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux2_pkt_arb.sv
// Packet-granular 2:1 arbiter: locks a stream until its last beat.
module mux2_pkt_arb
  import mux2_pkt_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_last,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_last,
  output logic             i1_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             s
);

  state_t r_state, w_state_nxt;
  logic   r_pri, w_pri_nxt;

  logic           w_pipe_rdy;
  logic           w_acc0, w_acc1;
  logic           w_in_valid;
  logic [WIDTH:0] w_in_data;
  logic [WIDTH:0] w_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pri   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pri   <= w_pri_nxt;
    end
  end

  always_comb begin
    i0_ready = !rst && (r_state == LOCK0) && w_pipe_rdy;
    i1_ready = !rst && (r_state == LOCK1) && w_pipe_rdy;
    w_acc0   = i0_valid && i0_ready;
    w_acc1   = i1_valid && i1_ready;
    w_in_valid = w_acc0 || w_acc1;
    w_in_data  = w_acc1 ? {i1_last, i1_data}
                        : {i0_last, i0_data};
  end

  // Grant on the cycle after request; release on accepted last beat
  always_comb begin
    w_state_nxt = r_state;
    w_pri_nxt   = r_pri;
    unique case (r_state)
      IDLE: begin
        if (i0_valid && (!i1_valid || !r_pri))
          w_state_nxt = LOCK0;
        else if (i1_valid)
          w_state_nxt = LOCK1;
      end
      LOCK0: begin
        if (w_acc0 && i0_last) begin
          w_state_nxt = IDLE;
          w_pri_nxt   = 1'b1;
        end
      end
      LOCK1: begin
        if (w_acc1 && i1_last) begin
          w_state_nxt = IDLE;
          w_pri_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s = (r_state == LOCK1);

  pipe_reg #(
    .W(WIDTH + 1)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_in_valid),
    .i_data  (w_in_data),
    .o_ready (w_pipe_rdy),
    .o_valid (y_valid),
    .o_data  (w_out),
    .i_ready (y_ready)
  );

  assign y_last = w_out[WIDTH];
  assign y_data = w_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux2_pkt_arb.sv
// Scoreboard bench for mux2_pkt_arb with directed packet scenarios.
module tb_mux2_pkt_arb;
  import mux2_pkt_arb_pkg::*;

  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic       i0_valid, i0_last, i0_ready;
  logic [7:0] i0_data;
  logic       i1_valid, i1_last, i1_ready;
  logic [7:0] i1_data;
  logic       y_valid, y_last, y_ready;
  logic [7:0] y_data;
  logic       s;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  mux2_pkt_arb #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i0_valid (i0_valid),
    .i0_data  (i0_data),
    .i0_last  (i0_last),
    .i0_ready (i0_ready),
    .i1_valid (i1_valid),
    .i1_data  (i1_data),
    .i1_last  (i1_last),
    .i1_ready (i1_ready),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_last   (y_last),
    .y_ready  (y_ready),
    .s        (s)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic push_pkt(input byte_q_t d);
    for (int k = 0; k < d.size(); k++)
      exp_q.push_back({(k == d.size() - 1), d[k]});
  endtask

  task automatic drv(input int st, input logic v,
                     input logic [7:0] d, input logic l);
    if (st == 0) begin
      i0_valid = v; i0_data = d; i0_last = l;
    end else begin
      i1_valid = v; i1_data = d; i1_last = l;
    end
  endtask

  function automatic logic rdy(input int st);
    return (st == 0) ? i0_ready : i1_ready;
  endfunction

  task automatic send(input int st, input byte_q_t d,
                      input int gap_after, input int gap_len);
    int n;
    for (int k = 0; k < d.size(); k++) begin
      drv(st, 1'b1, d[k], (k == d.size() - 1));
      @(negedge clk);
      n = 0;
      while (!rdy(st) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout stream=%0d got=stalled want=ready", st);
      end
      @(posedge clk); #1;
      if (k == gap_after) begin
        drv(st, 1'b0, 8'h00, 1'b0);
        repeat (gap_len) begin
          @(posedge clk); #1;
        end
      end
    end
    drv(st, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every downstream handshake must match the next expected beat
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && y_valid && y_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_extra got=%0h want=none", {y_last, y_data});
      end else begin
        e = exp_q.pop_front();
        if ({y_last, y_data} !== e) begin
          bad++;
          $display("FAIL mon_beat got=%0h want=%0h", {y_last, y_data}, e);
        end
      end
    end
  end

  initial begin
    byte_q_t qa, qb;
    int n, gaps;

    rst = 1'b1;
    y_ready = 1'b0;
    drv(0, 1'b1, 8'hAA, 1'b0);
    drv(1, 1'b1, 8'hBB, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    check("rst_s", s, 0);
    check("rst_i0_ready", i0_ready, 0);
    check("rst_i1_ready", i1_ready, 0);
    check("rst_state", dut.r_state, IDLE);
    check("rst_pri", dut.r_pri, 0);
    drv(0, 1'b0, 8'h00, 1'b0);
    drv(1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    y_ready = 1'b1;
    @(posedge clk); #1;

    // Single packet with latency
    qa = {8'h11, 8'h22, 8'h33};
    push_pkt(qa);
    fork
      send(0, qa, -1, 0);
      begin
        @(negedge clk);
        check("t1_idle_y_valid", y_valid, 0);
        check("t1_idle_i0_ready", i0_ready, 0);
        @(negedge clk);
        check("t1_lock_y_valid", y_valid, 0);
        check("t1_lock_i0_ready", i0_ready, 1);
        check("t1_s", s, 0);
        @(negedge clk);
        check("t1_beat0", {y_valid, y_last, y_data}, 10'h211);
        @(negedge clk);
        check("t1_beat1", {y_valid, y_last, y_data}, 10'h222);
        @(negedge clk);
        check("t1_beat2", {y_valid, y_last, y_data}, 10'h333);
      end
    join
    drain("t1_drain");
    check("t1_pri", dut.r_pri, 1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention from IDLE with pri=0
    qa = {8'hA0, 8'hA1};
    qb = {8'hB0, 8'hB1};
    push_pkt(qa);
    push_pkt(qb);
    fork
      send(0, qa, -1, 0);
      send(1, qb, -1, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t2_s_first", s, 0);
        check("t2_i0_ready", i0_ready, 1);
        check("t2_i1_ready", i1_ready, 0);
        @(negedge clk);
        @(negedge clk);
        check("t2_idle_between", dut.r_state, IDLE);
        check("t2_idle_s", s, 0);
        @(negedge clk);
        check("t2_s_second", s, 1);
        check("t2_i1_granted", i1_ready, 1);
      end
    join
    drain("t2_drain");
    check("t2_pri_end", dut.r_pri, 0);

    // Backpressure mid-packet
    qa = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    push_pkt(qa);
    fork
      send(0, qa, -1, 0);
      begin
        n = 0;
        @(negedge clk);
        while (!(y_valid && y_data == 8'hC1) && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("t3_saw_c1", (n < 50), 1);
        @(posedge clk); #1;
        y_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("t3_hold", {y_valid, y_data}, 9'h1C2);
          check("t3_i0_blocked", i0_ready, 0);
        end
        @(posedge clk); #1;
        y_ready = 1'b1;
      end
    join
    drain("t3_drain");

    // Lock hold across a 5-cycle gap
    qa = {8'hD0, 8'hD1, 8'hD2};
    qb = {8'hE0};
    push_pkt(qa);
    push_pkt(qb);
    gaps = 0;
    fork
      send(1, qa, 0, 5);
      begin
        @(posedge clk); #1;
        send(0, qb, -1, 0);
      end
      begin
        repeat (8) begin
          @(negedge clk);
          if (!i1_valid) begin
            gaps++;
            check("t4_gap_s", s, 1);
            check("t4_gap_i0_ready", i0_ready, 0);
          end
        end
        check("t4_gap_len", gaps, 5);
      end
    join
    drain("t4_drain");

    // Reset mid-packet
    check("t5_pri_before", dut.r_pri, 1);
    exp_q.push_back({1'b0, 8'hF0});
    drv(0, 1'b1, 8'hF0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drv(0, 1'b1, 8'hF1, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    y_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_y_valid", y_valid, 0);
    check("t5_state", dut.r_state, IDLE);
    check("t5_s", s, 0);
    check("t5_pri", dut.r_pri, 0);
    check("t5_i0_ready", i0_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_no_beat", y_valid, 0);
    check("t5_f0_seen", exp_q.size(), 0);
    y_ready = 1'b1;
    qb = {8'h5A};
    push_pkt(qb);
    send(1, qb, -1, 0);
    drain("t5_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
